// File: rtl/sdram_frame_burst_reader.sv
// sdram_frame_burst_reader
//   Streams whole video frames out of one of two SDRAM frame buffers with
//   Avalon-MM read bursts. It issues a burst only when the prefetch FIFO can
//   hold the whole burst, counting data still in flight. Pixel words leave
//   through a first-word-fall-through valid/ready stream tagged with
//   start-of-frame.
//
// Ports
//   sdram_clk, rst            clock, synchronous active-high reset
//   frame_ready_i, buf_sel_i  frame request and buffer select (latched at start)
//   frame_start_o             1-cycle pulse, first cycle of RUN
//   frame_done_o              1-cycle pulse once every word of the frame is in the FIFO
//   first_fill_o              sticky, FIFO level reached FILL_THRESH
//   sdram_*                   Avalon-MM burst read master
//   pix_data_o/sof/valid      FWFT stream head; pop on pix_valid_o && pix_ready_i
//   fifo_level_o              FIFO occupancy
//
// Optional build macro SDRAM_READER_STATS_EN adds underrun_cnt_o (saturating
// count of starved ready cycles after first fill) and frame_cnt_o (wrapping
// count of completed frames).
module sdram_frame_burst_reader #(
  parameter int                    DATA_WIDTH  = 64,
  parameter int                    ADDR_WIDTH  = 29,
  parameter int                    BURST_LEN   = 16,
  parameter int                    FIFO_DEPTH  = 256,
  parameter logic [31:0]           FRAME_WORDS = 32'hFD200,
  parameter logic [ADDR_WIDTH-1:0] BUF0_BASE   = 'h400_0000,
  parameter logic [ADDR_WIDTH-1:0] BUF1_BASE   = 'h420_0000,
  parameter int                    FILL_THRESH = 128
) (
  input  logic                          sdram_clk,
  input  logic                          rst,
  input  logic                          frame_ready_i,
  input  logic                          buf_sel_i,
  output logic                          frame_start_o,
  output logic                          frame_done_o,
  output logic                          first_fill_o,
  output logic [ADDR_WIDTH-1:0]         sdram_address_o,
  output logic [7:0]                    sdram_burstcount_o,
  output logic                          sdram_read_o,
  input  logic                          sdram_waitrequest_i,
  input  logic [DATA_WIDTH-1:0]         sdram_readdata_i,
  input  logic                          sdram_readdatavalid_i,
  output logic [DATA_WIDTH-1:0]         pix_data_o,
  output logic                          pix_sof_o,
  output logic                          pix_valid_o,
  input  logic                          pix_ready_i,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
`ifdef SDRAM_READER_STATS_EN
  ,
  output logic [31:0]                   underrun_cnt_o,
  output logic [15:0]                   frame_cnt_o
`endif
);

  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1;
  localparam int PTR_W      = $clog2(FIFO_DEPTH);
  localparam int NUM_BURSTS = int'(FRAME_WORDS) / BURST_LEN;
  localparam int BIDX_W     = $clog2(NUM_BURSTS + 1);
  localparam int RX_W       = $clog2(int'(FRAME_WORDS) + 1);
  localparam int BL_SH      = $clog2(BURST_LEN);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   base_q, base_d;
  logic [BIDX_W-1:0]       bidx_q, bidx_d;
  logic [RX_W-1:0]         rx_q, rx_d;
  logic [LVL_W-1:0]        outst_q, outst_d;
  logic [LVL_W-1:0]        level_q, level_d;
  logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
  logic                    read_q, read_d;
  logic                    start_q, start_d;
  logic                    ff_q;

  logic                    accept, wr_en, pop, space_ok;
  logic [LVL_W:0]          committed;
  logic [DATA_WIDTH:0]     mem [FIFO_DEPTH];
  logic [DATA_WIDTH:0]     head;

  assign accept = read_q && !sdram_waitrequest_i;
  // Words arriving with nothing outstanding (stale data after a reset) are dropped.
  assign wr_en  = sdram_readdatavalid_i && (outst_q != '0);
  assign pop    = pix_ready_i && (level_q != '0);

  assign level_d = level_q + LVL_W'(wr_en) - LVL_W'(pop);
  assign outst_d = outst_q + (accept ? LVL_W'(BURST_LEN) : '0) - LVL_W'(wr_en);

  // Space is judged on next-cycle occupancy, so the request raised for the
  // next cycle already accounts for everything committed this cycle. While a
  // request waits, space can only grow (writes move words from outstanding
  // into the FIFO, pops free slots).
  assign committed = {1'b0, level_d} + {1'b0, outst_d};
  assign space_ok  = committed <= (LVL_W+1)'(FIFO_DEPTH - BURST_LEN);

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    bidx_d  = bidx_q;
    rx_d    = rx_q;
    read_d  = read_q;
    start_d = 1'b0;
    if (wr_en) rx_d = rx_q + RX_W'(1);
    unique case (state_q)
      IDLE: begin
        read_d = 1'b0;
        if (frame_ready_i) begin
          state_d = RUN;
          base_d  = buf_sel_i ? BUF1_BASE : BUF0_BASE;
          bidx_d  = '0;
          rx_d    = '0;
          start_d = 1'b1;
        end
      end
      RUN: begin
        if (accept) begin
          bidx_d = bidx_q + BIDX_W'(1);
          if (bidx_q == BIDX_W'(NUM_BURSTS - 1)) state_d = DRAIN;
        end
        // Hold the request (and thus address/burstcount) through waitrequest.
        if (read_q && sdram_waitrequest_i) read_d = 1'b1;
        else                               read_d = (state_d == RUN) && space_ok;
      end
      DRAIN: begin
        read_d = 1'b0;
        if (rx_q == RX_W'(FRAME_WORDS)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sdram_clk) begin
    if (rst) begin
      state_q  <= IDLE;
      base_q   <= '0;
      bidx_q   <= '0;
      rx_q     <= '0;
      outst_q  <= '0;
      level_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      read_q   <= 1'b0;
      start_q  <= 1'b0;
      ff_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      bidx_q  <= bidx_d;
      rx_q    <= rx_d;
      outst_q <= outst_d;
      level_q <= level_d;
      read_q  <= read_d;
      start_q <= start_d;
      if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (level_q >= LVL_W'(FILL_THRESH)) ff_q <= 1'b1;
    end
  end

  // FIFO storage: {sof, data}. Not reset; the head is masked while empty.
  always_ff @(posedge sdram_clk) begin
    if (wr_en) mem[wr_ptr_q] <= {(rx_q == '0), sdram_readdata_i};
  end

  assign head = mem[rd_ptr_q];

  assign sdram_read_o       = read_q;
  assign sdram_address_o    = base_q + (ADDR_WIDTH'(bidx_q) << BL_SH);
  // Burstcount only carries meaning with read; zero otherwise keeps reset state clean.
  assign sdram_burstcount_o = read_q ? 8'(BURST_LEN) : 8'd0;
  assign frame_start_o      = start_q;
  assign frame_done_o       = (state_q == DRAIN) && (rx_q == RX_W'(FRAME_WORDS));
  assign first_fill_o       = ff_q;
  assign fifo_level_o       = level_q;
  assign pix_valid_o        = (level_q != '0);
  assign pix_data_o         = pix_valid_o ? head[DATA_WIDTH-1:0] : '0;
  assign pix_sof_o          = pix_valid_o && head[DATA_WIDTH];

  // The space rule makes a write into a full FIFO impossible.
  assert property (@(posedge sdram_clk) disable iff (rst)
                   !(wr_en && (level_q == LVL_W'(FIFO_DEPTH))));

`ifdef SDRAM_READER_STATS_EN
  logic [31:0] und_q;
  logic [15:0] fcnt_q;

  always_ff @(posedge sdram_clk) begin
    if (rst) begin
      und_q  <= '0;
      fcnt_q <= '0;
    end else begin
      if (ff_q && pix_ready_i && !pix_valid_o && (und_q != '1)) und_q <= und_q + 32'd1;
      if (frame_done_o) fcnt_q <= fcnt_q + 16'd1;
    end
  end

  assign underrun_cnt_o = und_q;
  assign frame_cnt_o    = fcnt_q;
`endif

endmodule
